// File: rtl/rggen_irq_coalescing_ctrl.sv
// Interrupt coalescing sequencer for a bank of hardware-set, software-cleared
// status fields. Event pulses go straight to the field set strobes. Enabled
// events are counted, and one level interrupt is raised on a count threshold
// or a timeout. The interrupt is held until software clears every enabled
// pending bit, and is then followed by a hold-off gap.
module rggen_irq_coalescing_ctrl #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned COUNT_WIDTH = 8,
   parameter int unsigned TIMER_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       i_event,
   input  logic [WIDTH-1:0]       i_enable,
   input  logic [WIDTH-1:0]       i_status,
   input  logic [COUNT_WIDTH-1:0] i_threshold,
   input  logic [TIMER_WIDTH-1:0] i_timeout,
   input  logic [TIMER_WIDTH-1:0] i_holdoff,
   output logic [WIDTH-1:0]       o_set,
   output logic                   o_irq,
   output logic [COUNT_WIDTH-1:0] o_count,
   output logic                   o_busy
);

   localparam int unsigned POP_WIDTH = $clog2(WIDTH + 1);
   localparam int unsigned SUM_WIDTH =
      ((COUNT_WIDTH > POP_WIDTH) ? COUNT_WIDTH : POP_WIDTH) + 1;
   localparam int unsigned TW1 = TIMER_WIDTH + 1;
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
   localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;

   typedef enum logic [1:0] {StIdle, StCollect, StAssert, StHoldoff} state_e;

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic                   irq_q, irq_d;
   // Set on the first COLLECT cycle, where i_status does not yet reflect the
   // events that caused entry.
   logic                   entry_q, entry_d;

   logic [POP_WIDTH-1:0]   pop;
   logic [SUM_WIDTH-1:0]   sum;
   logic [COUNT_WIDTH-1:0] count_nxt;
   logic [COUNT_WIDTH-1:0] thr_eff;
   logic [TIMER_WIDTH-1:0] holdoff_eff;
   logic [TIMER_WIDTH-1:0] timer_inc;
   logic                   pop_any;
   logic                   pending;
   logic                   thr_hit;
   logic                   timeout_hit;
   logic                   holdoff_done;

   // Event pulses feed the field set inputs with no latency.
   assign o_set   = i_event;
   assign o_irq   = irq_q;
   assign o_count = count_q;
   assign o_busy  = (state_q != StIdle);

   // Number of enabled events this cycle.
   always_comb begin
      pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + POP_WIDTH'(i_event[i] & i_enable[i]);
      end
   end

   // Saturating count, effective threshold/hold-off and timer conditions.
   always_comb begin
      sum          = SUM_WIDTH'(count_q) + SUM_WIDTH'(pop);
      count_nxt    = (sum > SUM_WIDTH'(COUNT_MAX)) ? COUNT_MAX : COUNT_WIDTH'(sum);
      thr_eff      = (i_threshold == '0) ? COUNT_WIDTH'(1) : i_threshold;
      holdoff_eff  = (i_holdoff == '0) ? TIMER_WIDTH'(1) : i_holdoff;
      timer_inc    = (timer_q == TIMER_MAX) ? TIMER_MAX : timer_q + TIMER_WIDTH'(1);
      pop_any      = |(i_event & i_enable);
      pending      = |(i_status & i_enable);
      thr_hit      = (count_nxt >= thr_eff);
      timeout_hit  = (i_timeout != '0) && (timer_q >= i_timeout);
      holdoff_done = (({1'b0, timer_q} + TW1'(1)) >= {1'b0, holdoff_eff});
   end

   // Next-state logic for the coalescing sequencer.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      timer_d = timer_q;
      entry_d = 1'b0;
      case (state_q)
         StIdle: begin
            count_d = '0;
            timer_d = '0;
            if (pop_any) begin
               count_d = count_nxt;
               if (thr_hit) begin
                  state_d = StAssert;
               end else begin
                  state_d = StCollect;
                  timer_d = TIMER_WIDTH'(1);
                  entry_d = 1'b1;
               end
            end
         end
         StCollect: begin
            count_d = count_nxt;
            timer_d = timer_inc;
            if (thr_hit) begin
               state_d = StAssert;
            end else if (!entry_q && timeout_hit) begin
               state_d = StAssert;
            end else if (!entry_q && !pending && !pop_any) begin
               // Software cleared everything before the interrupt fired.
               state_d = StIdle;
               count_d = '0;
               timer_d = '0;
            end
         end
         StAssert: begin
            count_d = count_nxt;
            if (!pending && !pop_any) begin
               state_d = StHoldoff;
               count_d = '0;
               timer_d = '0;
            end
         end
         StHoldoff: begin
            count_d = count_nxt;
            timer_d = timer_inc;
            if (holdoff_done) begin
               if (thr_hit) begin
                  state_d = StAssert;
               end else if (pending || pop_any) begin
                  state_d = StCollect;
                  timer_d = TIMER_WIDTH'(1);
                  entry_d = 1'b1;
               end else begin
                  state_d = StIdle;
                  count_d = '0;
                  timer_d = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            count_d = '0;
            timer_d = '0;
         end
      endcase
      irq_d = (state_d == StAssert);
   end

   // State, counter, timer and registered interrupt level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= '0;
         timer_q <= '0;
         irq_q   <= 1'b0;
         entry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         timer_q <= timer_d;
         irq_q   <= irq_d;
         entry_q <= entry_d;
      end
   end

endmodule

// File: tb/tb_rggen_irq_coalescing_ctrl.sv
// Scoreboard bench for rggen_irq_coalescing_ctrl. Stimulus pushes expected
// output values tagged with a cycle number; a monitor compares on the falling
// edge of that cycle. A W1C status-field model with set priority closes the
// loop from o_set back to i_status.
module tb_rggen_irq_coalescing_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ev, en, status, clr;
   logic [7:0] thr;
   logic [15:0] tmo, hold;
   logic [7:0] o_set;
   logic       o_irq;
   logic [7:0] o_count;
   logic       o_busy;

   typedef struct {
      int    cyc;
      int    sel;   // 0 irq, 1 count, 2 busy, 3 set
      int    val;
      string name;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   act;
   int   base;

   rggen_irq_coalescing_ctrl #(
      .WIDTH       (8),
      .COUNT_WIDTH (8),
      .TIMER_WIDTH (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_event     (ev),
      .i_enable    (en),
      .i_status    (status),
      .i_threshold (thr),
      .i_timeout   (tmo),
      .i_holdoff   (hold),
      .o_set       (o_set),
      .o_irq       (o_irq),
      .o_count     (o_count),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Status field model: set has priority over software clear.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) status <= 8'h00;
      else        status <= (status & ~clr) | o_set;
   end

   // Monitor: compare every expectation tagged with the current cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            case (sb[i].sel)
               0:       act = int'(o_irq);
               1:       act = int'(o_count);
               2:       act = int'(o_busy);
               default: act = int'(o_set);
            endcase
            total++;
            if (act != sb[i].val) begin
               bad++;
               $display("FAIL %s cyc=%0d got=%0h want=%0h", sb[i].name, cyc, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int c, input int sel, input int val, input string name);
      exp_t e;
      e.cyc  = c;
      e.sel  = sel;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0;
      ev    = 8'h5A;
      en    = 8'hFF;
      clr   = 8'h00;
      thr   = 8'd3;
      tmo   = 16'd0;
      hold  = 16'd1;
      expect_at(1, 0, 0, "rst_irq");
      expect_at(1, 1, 0, "rst_count");
      expect_at(1, 2, 0, "rst_busy");
      expect_at(1, 3, 'h5A, "rst_set");
      tick();
      tick();
      total++;
      if (o_irq !== 1'b0) begin
         bad++;
         $display("FAIL d_rst_irq got=%0h want=0", o_irq);
      end
      total++;
      if (o_count !== 8'h00) begin
         bad++;
         $display("FAIL d_rst_count got=%0h want=0", o_count);
      end
      total++;
      if (o_busy !== 1'b0) begin
         bad++;
         $display("FAIL d_rst_busy got=%0h want=0", o_busy);
      end
      total++;
      if (o_set !== ev) begin
         bad++;
         $display("FAIL d_rst_set got=%0h want=%0h", o_set, ev);
      end
      rst_n = 1'b1;
      ev    = 8'h00;

      // Threshold of 3 reached by the third enabled event.
      base = cyc;
      for (int k = 0; k <= 10; k++) begin
         ev  = (k == 0 || k == 2 || k == 4) ? 8'h01 : 8'h00;
         clr = (k == 6) ? 8'h01 : 8'h00;
         case (k)
            1: begin expect_at(base + k, 2, 1, "t1_busy"); expect_at(base + k, 1, 1, "t1_cnt1"); end
            3: begin expect_at(base + k, 0, 0, "t1_noirq2"); expect_at(base + k, 1, 2, "t1_cnt2"); end
            4: expect_at(base + k, 0, 0, "t1_noirq");
            5: begin expect_at(base + k, 0, 1, "t1_irq"); expect_at(base + k, 1, 3, "t1_cnt3"); end
            7: expect_at(base + k, 0, 1, "t1_hold");
            8: begin
               expect_at(base + k, 0, 0, "t1_drop");
               expect_at(base + k, 2, 1, "t1_hobusy");
               expect_at(base + k, 1, 0, "t1_hocnt");
            end
            9: expect_at(base + k, 2, 0, "t1_idle");
            default: ;
         endcase
         tick();
      end

      // Timeout of 20 after a single event under a high threshold.
      thr  = 8'd10;
      tmo  = 16'd20;
      base = cyc;
      for (int k = 0; k <= 25; k++) begin
         ev  = (k == 0) ? 8'h02 : 8'h00;
         clr = (k == 22) ? 8'h02 : 8'h00;
         case (k)
            10: begin expect_at(base + k, 2, 1, "t2_busy"); expect_at(base + k, 0, 0, "t2_wait"); end
            20: expect_at(base + k, 0, 0, "t2_pre");
            21: begin expect_at(base + k, 0, 1, "t2_irq"); expect_at(base + k, 1, 1, "t2_cnt"); end
            23: expect_at(base + k, 0, 1, "t2_hold");
            24: begin expect_at(base + k, 0, 0, "t2_drop"); expect_at(base + k, 2, 1, "t2_hobusy"); end
            25: expect_at(base + k, 2, 0, "t2_idle");
            default: ;
         endcase
         tick();
      end

      // Partial clear keeps irq; full clear drops it; event during hold-off.
      tmo  = 16'd0;
      hold = 16'd5;
      base = cyc;
      for (int k = 0; k <= 21; k++) begin
         thr = (k >= 8) ? 8'd1 : 8'd2;
         case (k)
            0:       ev = 8'h03;
            4:       ev = 8'h02;
            9:       ev = 8'h04;
            default: ev = 8'h00;
         endcase
         case (k)
            2:       clr = 8'h01;
            4:       clr = 8'h02;
            6:       clr = 8'h02;
            14:      clr = 8'h04;
            default: clr = 8'h00;
         endcase
         case (k)
            1: begin expect_at(base + k, 0, 1, "t3_irq"); expect_at(base + k, 1, 2, "t3_cnt2"); end
            3: expect_at(base + k, 0, 1, "t3_partial");
            4: expect_at(base + k, 0, 1, "t3_partial2");
            5: begin expect_at(base + k, 0, 1, "t3_setprio"); expect_at(base + k, 1, 3, "t3_cnt3"); end
            7: expect_at(base + k, 0, 1, "t3_lastcyc");
            8: begin
               expect_at(base + k, 0, 0, "t3_drop");
               expect_at(base + k, 2, 1, "t3_hobusy");
               expect_at(base + k, 1, 0, "t3_hocnt");
            end
            9:  expect_at(base + k, 0, 0, "t4_ho1");
            10: begin expect_at(base + k, 0, 0, "t4_ho2"); expect_at(base + k, 1, 1, "t4_hocnt"); end
            11: expect_at(base + k, 0, 0, "t4_ho3");
            12: expect_at(base + k, 0, 0, "t4_ho4");
            13: begin expect_at(base + k, 0, 1, "t4_irq"); expect_at(base + k, 1, 1, "t4_cnt"); end
            20: expect_at(base + k, 2, 1, "t4_holast");
            21: expect_at(base + k, 2, 0, "t4_idle");
            default: ;
         endcase
         tick();
      end

      // Disabled sources set status only; then enabled source via COLLECT.
      thr  = 8'd2;
      hold = 16'd1;
      base = cyc;
      for (int k = 0; k <= 10; k++) begin
         en = (k >= 2) ? 8'h01 : 8'h00;
         case (k)
            0:       ev = 8'hFF;
            3:       ev = 8'h01;
            5:       ev = 8'h01;
            default: ev = 8'h00;
         endcase
         clr = (k == 7) ? 8'hFF : 8'h00;
         if (k == 0) begin
            #1;
            total++;
            if (o_set !== 8'hFF) begin
               bad++;
               $display("FAIL d_t5_set got=%0h want=ff", o_set);
            end
         end
         case (k)
            0: expect_at(base + k, 3, 'hFF, "t5_set");
            1: begin
               expect_at(base + k, 0, 0, "t5_noirq");
               expect_at(base + k, 1, 0, "t5_nocnt");
               expect_at(base + k, 2, 0, "t5_nobusy");
            end
            2: expect_at(base + k, 2, 0, "t5_idlepend");
            4: begin
               expect_at(base + k, 2, 1, "t5_collect");
               expect_at(base + k, 1, 1, "t5_cnt1");
               expect_at(base + k, 0, 0, "t5_noirq2");
            end
            5: expect_at(base + k, 0, 0, "t5_noirq3");
            6: begin expect_at(base + k, 0, 1, "t5_irq"); expect_at(base + k, 1, 2, "t5_cnt2"); end
            8:  expect_at(base + k, 0, 1, "t5_hold");
            9:  expect_at(base + k, 0, 0, "t5_drop");
            10: expect_at(base + k, 2, 0, "t5_idle");
            default: ;
         endcase
         tick();
      end

      // Async reset in ASSERT, restart with threshold 0, count saturation.
      en   = 8'hFF;
      base = cyc;
      for (int k = 0; k <= 40; k++) begin
         thr   = (k >= 3) ? 8'd0 : 8'd7;
         rst_n = (k == 2) ? 1'b0 : 1'b1;
         if (k == 0)                ev = 8'h7F;
         else if (k == 4)           ev = 8'h01;
         else if (k >= 5 && k <= 36) ev = 8'hFF;
         else                       ev = 8'h00;
         clr = 8'h00;
         case (k)
            1: begin
               expect_at(base + k, 0, 1, "t6_irq");
               expect_at(base + k, 1, 7, "t6_cnt7");
               expect_at(base + k, 2, 1, "t6_busy");
            end
            2: begin
               expect_at(base + k, 0, 0, "t6_rstirq");
               expect_at(base + k, 1, 0, "t6_rstcnt");
               expect_at(base + k, 2, 0, "t6_rstbusy");
            end
            4: begin expect_at(base + k, 2, 0, "t6_idle"); expect_at(base + k, 0, 0, "t6_noirq"); end
            5: begin expect_at(base + k, 0, 1, "t6_thr0irq"); expect_at(base + k, 1, 1, "t6_cnt1"); end
            6: expect_at(base + k, 1, 9, "t6_cnt9");
            37: begin expect_at(base + k, 1, 255, "t7_sat"); expect_at(base + k, 0, 1, "t7_irq"); end
            default: ;
         endcase
         tick();
      end

      tick();
      tick();
      foreach (sb[i]) begin
         total++;
         bad++;
         $display("FAIL unchecked_%s cyc=%0d got=none want=%0h", sb[i].name, sb[i].cyc, sb[i].val);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
